// File: rtl/loop_counter_if.sv
// loop_counter_if: control, configuration and status bundle for loop_counter.
//   master : drives start/abort/en and cfg_*; observes count/busy/done/wrap/err/iter
//   slave  : the loop counter itself
interface loop_counter_if #(
    parameter int WIDTH  = 4,
    parameter int ITER_W = 8
);
    logic              start;
    logic              abort;
    logic              en;
    logic [WIDTH-1:0]  cfg_lo;
    logic [WIDTH-1:0]  cfg_hi;
    logic [WIDTH-1:0]  cfg_step;
    logic              cfg_down;
    logic              cfg_repeat;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic              wrap;
    logic              err;
    logic [ITER_W-1:0] iter;

    modport master (
        output start, abort, en, cfg_lo, cfg_hi, cfg_step, cfg_down, cfg_repeat,
        input  count, busy, done, wrap, err, iter
    );

    modport slave (
        input  start, abort, en, cfg_lo, cfg_hi, cfg_step, cfg_down, cfg_repeat,
        output count, busy, done, wrap, err, iter
    );
endinterface

// File: rtl/loop_counter.sv
// loop_counter: bounded loop sequencer, the hardware form of
// "while (count <= limit) count += step", with up/down direction and repeat.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : loop_counter_if slave (start/abort/en, cfg_*, count/busy/done/wrap/err/iter)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; config not yet latched, count holds
// RUN   | stepping count by the latched step each cycle en=1
module loop_counter #(
    parameter int WIDTH  = 4,
    parameter int ITER_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    loop_counter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [WIDTH-1:0]  lo_q, hi_q, step_q;
    logic              down_q, repeat_q;
    logic [WIDTH-1:0]  count_q;
    logic [ITER_W-1:0] iter_q;
    logic              busy_q, done_q, wrap_q, err_q;

    logic [WIDTH:0]    nxt;
    logic              term;
    logic [ITER_W-1:0] iter_inc;

    // One extra bit so neither overflow past the top nor borrow below zero
    // can alias back into range.
    always_comb begin
        nxt  = '0;
        term = 1'b0;
        if (down_q) begin
            nxt  = {1'b0, count_q} - {1'b0, step_q};
            term = nxt[WIDTH] || (nxt[WIDTH-1:0] < lo_q);
        end else begin
            nxt  = {1'b0, count_q} + {1'b0, step_q};
            term = nxt > {1'b0, hi_q};
        end
    end

    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            step_q   <= '0;
            down_q   <= 1'b0;
            repeat_q <= 1'b0;
            count_q  <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    // abort outranks start even while idle
                    if (bus.start && !bus.abort) begin
                        if (bus.cfg_lo <= bus.cfg_hi) begin
                            lo_q     <= bus.cfg_lo;
                            hi_q     <= bus.cfg_hi;
                            step_q   <= (bus.cfg_step == '0) ? WIDTH'(1) : bus.cfg_step;
                            down_q   <= bus.cfg_down;
                            repeat_q <= bus.cfg_repeat;
                            count_q  <= bus.cfg_down ? bus.cfg_hi : bus.cfg_lo;
                            iter_q   <= '0;
                            busy_q   <= 1'b1;
                            state    <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.en) begin
                        if (!term) begin
                            count_q <= nxt[WIDTH-1:0];
                        end else if (repeat_q) begin
                            count_q <= down_q ? hi_q : lo_q;
                            wrap_q  <= 1'b1;
                            iter_q  <= iter_inc;
                        end else begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            iter_q <= iter_inc;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;
    assign bus.iter  = iter_q;
endmodule

// File: tb/tb_loop_counter.sv
module tb_loop_counter;
    localparam int WIDTH  = 4;
    localparam int ITER_W = 8;
    localparam int ITER_MAX = (1 << ITER_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    loop_counter_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

    loop_counter #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: on start the whole pass is listed explicitly; running
    // just walks an index through that list.
    int seq[$];
    int idx;
    bit m_active, m_rep;
    int m_count, m_iter;
    bit m_done, m_wrap, m_err;

    function automatic void model_reset();
        seq.delete();
        idx      = 0;
        m_active = 0;
        m_rep    = 0;
        m_count  = 0;
        m_iter   = 0;
        m_done   = 0;
        m_wrap   = 0;
        m_err    = 0;
    endfunction

    function automatic void model_step();
        int lo, hi, st;
        m_done = 0;
        m_wrap = 0;
        m_err  = 0;
        if (!m_active) begin
            if (bus.start && !bus.abort) begin
                lo = int'(bus.cfg_lo);
                hi = int'(bus.cfg_hi);
                st = (bus.cfg_step == 0) ? 1 : int'(bus.cfg_step);
                if (lo <= hi) begin
                    seq.delete();
                    if (!bus.cfg_down) for (int v = lo; v <= hi; v += st) seq.push_back(v);
                    else               for (int v = hi; v >= lo; v -= st) seq.push_back(v);
                    idx      = 0;
                    m_count  = seq[0];
                    m_iter   = 0;
                    m_rep    = bus.cfg_repeat;
                    m_active = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (bus.abort) begin
            m_active = 0;
        end else if (bus.en) begin
            if (idx + 1 < seq.size()) begin
                idx++;
                m_count = seq[idx];
            end else begin
                if (m_iter < ITER_MAX) m_iter++;
                if (m_rep) begin
                    idx     = 0;
                    m_count = seq[0];
                    m_wrap  = 1;
                end else begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    endfunction

    task automatic check();
        vectors++;
        if (bus.count !== WIDTH'(m_count) || bus.busy !== m_active || bus.done !== m_done ||
            bus.wrap !== m_wrap || bus.err !== m_err || bus.iter !== ITER_W'(m_iter)) begin
            miscompares++;
            $display("FAIL outputs t=%0t count=%0d/%0d busy=%b/%b done=%b/%b wrap=%b/%b err=%b/%b iter=%0d/%0d (got/exp)",
                     $time, bus.count, m_count, bus.busy, m_active, bus.done, m_done,
                     bus.wrap, m_wrap, bus.err, m_err, bus.iter, m_iter);
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check();
    endtask

    task automatic set_cfg(input int lo, input int hi, input int st, input bit dn, input bit rp);
        bus.cfg_lo     = WIDTH'(lo);
        bus.cfg_hi     = WIDTH'(hi);
        bus.cfg_step   = WIDTH'(st);
        bus.cfg_down   = dn;
        bus.cfg_repeat = rp;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    // Called just after a check (posedge+1): reset lands mid-cycle, away from edges.
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.en    = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        #3;
        check();
        expect_eq("reset_count", int'(bus.count), 0);
        #9 rst_n = 1'b1;

        // lo=0 hi=10 step=1 up
        set_cfg(0, 10, 1, 0, 0);
        pulse_start();
        expect_eq("t1_first_count", int'(bus.count), 0);
        expect_eq("t1_busy", int'(bus.busy), 1);
        repeat (10) cycle();
        expect_eq("t1_last_count", int'(bus.count), 10);
        cycle();
        expect_eq("t1_done", int'(bus.done), 1);
        expect_eq("t1_done_count", int'(bus.count), 10);
        expect_eq("t1_busy_low", int'(bus.busy), 0);
        expect_eq("t1_iter", int'(bus.iter), 1);
        cycle();
        expect_eq("t1_done_one_cycle", int'(bus.done), 0);

        // full range, must terminate at 15
        set_cfg(0, 15, 1, 0, 0);
        pulse_start();
        repeat (16) cycle();
        expect_eq("t2_done", int'(bus.done), 1);
        expect_eq("t2_count", int'(bus.count), 15);

        // lo=2 hi=14 step=3 down: 14 11 8 5 2
        set_cfg(2, 14, 3, 1, 0);
        pulse_start();
        expect_eq("t3_first", int'(bus.count), 14);
        repeat (4) cycle();
        expect_eq("t3_last", int'(bus.count), 2);
        cycle();
        expect_eq("t3_done", int'(bus.done), 1);
        expect_eq("t3_count", int'(bus.count), 2);

        // repeat mode 0 4 8, abort after three passes
        set_cfg(0, 10, 4, 0, 1);
        pulse_start();
        repeat (2) cycle();
        expect_eq("t4_count8", int'(bus.count), 8);
        repeat (7) cycle();
        expect_eq("t4_wrap", int'(bus.wrap), 1);
        expect_eq("t4_iter", int'(bus.iter), 3);
        expect_eq("t4_reload", int'(bus.count), 0);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        expect_eq("t4_abort_busy", int'(bus.busy), 0);
        expect_eq("t4_abort_iter", int'(bus.iter), 3);
        expect_eq("t4_abort_done", int'(bus.done), 0);

        // pause, step=0 as 1
        set_cfg(1, 12, 0, 0, 0);
        pulse_start();
        repeat (3) cycle();
        expect_eq("t5_before_pause", int'(bus.count), 4);
        bus.en = 1'b0;
        repeat (3) cycle();
        expect_eq("t5_paused", int'(bus.count), 4);
        bus.en = 1'b1;
        cycle();
        expect_eq("t5_resumed", int'(bus.count), 5);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        set_cfg(9, 3, 1, 0, 0);
        pulse_start();
        expect_eq("t5_err", int'(bus.err), 1);
        expect_eq("t5_err_busy", int'(bus.busy), 0);
        expect_eq("t5_err_count", int'(bus.count), 5);
        cycle();
        expect_eq("t5_err_one_cycle", int'(bus.err), 0);

        // lo==hi repeat: wrap every cycle, iter saturates
        set_cfg(5, 5, 1, 0, 1);
        pulse_start();
        repeat (260) cycle();
        expect_eq("sat_iter", int'(bus.iter), ITER_MAX);
        expect_eq("sat_wrap", int'(bus.wrap), 1);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;

        // async reset mid-run
        set_cfg(0, 10, 1, 0, 0);
        pulse_start();
        repeat (5) cycle();
        expect_eq("t6_count5", int'(bus.count), 5);
        async_reset();
        expect_eq("t6_reset_count", int'(bus.count), 0);
        expect_eq("t6_reset_busy", int'(bus.busy), 0);
        set_cfg(0, 10, 1, 0, 0);
        pulse_start();
        expect_eq("t6_restart", int'(bus.count), 0);
        repeat (11) cycle();
        expect_eq("t6_done", int'(bus.done), 1);

        // randomized traffic, cfg churns every cycle
        for (int n = 0; n < 3000; n++) begin
            int lo, hi, t;
            lo = int'($urandom_range(0, 15));
            hi = int'($urandom_range(0, 15));
            if (lo > hi && $urandom_range(0, 7) != 0) begin
                t = lo; lo = hi; hi = t;
            end
            set_cfg(lo, hi, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
            bus.start = ($urandom_range(0, 3) == 0);
            bus.abort = !bus.start && ($urandom_range(0, 15) == 0);
            bus.en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
